// File: rtl/seg7_pkg.sv
// seg7_pkg
// Shared definitions for the seg7_scan_drv display driver:
//   - active-low segment codes {g,f,e,d,c,b,a} for the decimal digits,
//     the dash shown for invalid BCD codes and the all-off pattern
//   - width helpers for the slot counter and the digit index
package seg7_pkg;

    localparam logic [6:0] SEG_0    = 7'h40;
    localparam logic [6:0] SEG_1    = 7'h79;
    localparam logic [6:0] SEG_2    = 7'h24;
    localparam logic [6:0] SEG_3    = 7'h30;
    localparam logic [6:0] SEG_4    = 7'h19;
    localparam logic [6:0] SEG_5    = 7'h12;
    localparam logic [6:0] SEG_6    = 7'h02;
    localparam logic [6:0] SEG_7    = 7'h78;
    localparam logic [6:0] SEG_8    = 7'h00;
    localparam logic [6:0] SEG_9    = 7'h10;
    localparam logic [6:0] SEG_DASH = 7'h3F;
    localparam logic [6:0] SEG_OFF  = 7'h7F;

    // Slot counter width; kept at least one bit so degenerate dividers still elaborate.
    function automatic int cnt_width(input int scan_div);
        return (scan_div > 1) ? $clog2(scan_div) : 1;
    endfunction

    // Digit index width; a single-digit display still gets a one-bit index.
    function automatic int idx_width(input int ndig);
        return (ndig > 1) ? $clog2(ndig) : 1;
    endfunction

endpackage

// File: rtl/seg7_scan_drv_if.sv
// seg7_scan_drv_if
// Bundles the digit source side and the display side of the scan driver.
//   digits     : packed BCD digits, digits[3:0] is the rightmost digit
//   dp_in      : decimal point request per digit, 1 = lit
//   blank_lz   : 1 = blank leading zeros
//   seg        : {g,f,e,d,c,b,a}, active-low
//   dp         : decimal point segment, active-low
//   an         : anode enables, active-low
//   frame_tick : one-cycle pulse when the digit snapshot reloads
// master = the digit source / display consumer, slave = the scan driver.
interface seg7_scan_drv_if #(
    parameter int NDIG = 4
);

    logic [4*NDIG-1:0] digits;
    logic [NDIG-1:0]   dp_in;
    logic              blank_lz;
    logic [6:0]        seg;
    logic              dp;
    logic [NDIG-1:0]   an;
    logic              frame_tick;

    modport master (
        output digits, dp_in, blank_lz,
        input  seg, dp, an, frame_tick
    );

    modport slave (
        input  digits, dp_in, blank_lz,
        output seg, dp, an, frame_tick
    );

endinterface

// File: rtl/seg7_dec.sv
// seg7_dec
// Purely combinational BCD to 7-segment decoder.
//   bcd   : 4-bit BCD value
//   seg_n : {g,f,e,d,c,b,a}, active-low; codes 10..15 show a dash
module seg7_dec
    import seg7_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg_n
);

    // Anything outside 0..9 lights segment g only, so bad data is visible.
    always_comb begin
        seg_n = SEG_DASH;
        case (bcd)
            4'd0:    seg_n = SEG_0;
            4'd1:    seg_n = SEG_1;
            4'd2:    seg_n = SEG_2;
            4'd3:    seg_n = SEG_3;
            4'd4:    seg_n = SEG_4;
            4'd5:    seg_n = SEG_5;
            4'd6:    seg_n = SEG_6;
            4'd7:    seg_n = SEG_7;
            4'd8:    seg_n = SEG_8;
            4'd9:    seg_n = SEG_9;
            default: seg_n = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg7_scan_drv.sv
// seg7_scan_drv
// Time-multiplexed common-anode 7-segment driver. Each digit owns a slot of
// SCAN_DIV clocks; the first GUARD clocks of a slot keep every anode off to
// stop ghosting. The digit bus is snapshotted once per frame (on the last
// cycle of the last slot) so a changing counter never tears the display.
//   clk   : system clock, rising edge
//   rst_n : asynchronous reset, active-low
//   bus   : seg7_scan_drv_if slave modport (digits/dp_in/blank_lz in,
//           seg/dp/an/frame_tick out, all outputs registered)
module seg7_scan_drv
    import seg7_pkg::*;
#(
    parameter int NDIG     = 4,
    parameter int SCAN_DIV = 50000,
    parameter int GUARD    = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    seg7_scan_drv_if.slave  bus
);

    localparam int CW = cnt_width(SCAN_DIV);
    localparam int IW = idx_width(NDIG);

    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] GUARD_C  = CW'(GUARD);
    localparam logic [IW-1:0] IDX_LAST = IW'(NDIG - 1);

    logic [CW-1:0]     cnt_q, cnt_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [4*NDIG-1:0] snap_dig_q, snap_dig_d;
    logic [NDIG-1:0]   snap_dp_q, snap_dp_d;
    logic [6:0]        seg_q, seg_d;
    logic              dp_q, dp_d;
    logic [NDIG-1:0]   an_q, an_d;
    logic              frame_tick_q, frame_tick_d;

    logic              slot_end;
    logic              frame_end;
    logic [3:0]        cur_dig;
    logic [6:0]        dec_seg;
    logic [NDIG-1:0]   lz_mask;
    logic              run_zero;

    seg7_dec u_dec (
        .bcd   (cur_dig),
        .seg_n (dec_seg)
    );

    // Prescaler, digit index and the once-per-frame snapshot. With NDIG=1
    // IDX_LAST is 0, so idx stays 0 and every slot end is also a frame end.
    always_comb begin
        slot_end     = (cnt_q == CNT_LAST);
        frame_end    = slot_end && (idx_q == IDX_LAST);
        cnt_d        = slot_end ? '0 : cnt_q + CW'(1);
        idx_d        = idx_q;
        if (slot_end) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
        end
        snap_dig_d   = frame_end ? bus.digits : snap_dig_q;
        snap_dp_d    = frame_end ? bus.dp_in  : snap_dp_q;
        frame_tick_d = frame_end;
    end

    // Leading-zero mask: walk from the most significant digit down and keep
    // marking digits while everything at and above them is zero. Digit 0 is
    // never marked, and invalid codes are non-zero so they stop the run.
    always_comb begin
        lz_mask  = '0;
        run_zero = 1'b1;
        for (int i = NDIG - 1; i >= 0; i--) begin
            run_zero   = run_zero & (snap_dig_q[4*i +: 4] == 4'd0);
            lz_mask[i] = run_zero & (i != 0);
        end
    end

    // Output pattern for the current (idx, cnt). blank_lz is used live here,
    // and a blanked digit still gets its anode so the duty cycle is uniform.
    always_comb begin
        cur_dig = snap_dig_q[4*idx_q +: 4];
        an_d    = '1;
        seg_d   = SEG_OFF;
        dp_d    = 1'b1;
        if (cnt_q >= GUARD_C) begin
            an_d[idx_q] = 1'b0;
            seg_d       = (bus.blank_lz && lz_mask[idx_q]) ? SEG_OFF : dec_seg;
            dp_d        = ~snap_dp_q[idx_q];
        end
    end

    // All state and the registered outputs share one asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            snap_dig_q   <= '0;
            snap_dp_q    <= '0;
            seg_q        <= SEG_OFF;
            dp_q         <= 1'b1;
            an_q         <= '1;
            frame_tick_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            snap_dig_q   <= snap_dig_d;
            snap_dp_q    <= snap_dp_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            an_q         <= an_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign bus.seg        = seg_q;
    assign bus.dp         = dp_q;
    assign bus.an         = an_q;
    assign bus.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg7_scan_drv.sv
// tb_seg7_scan_drv
// Self-checking bench for seg7_scan_drv with NDIG=4, SCAN_DIV=8, GUARD=2.
// The reference model derives the expected outputs from the number of clock
// edges since reset: slot position, digit index and frame boundaries come
// from plain division/modulo, and the snapshot is a copy of the digit bus
// taken at each frame boundary.
module tb_seg7_scan_drv;

    localparam int NDIG     = 4;
    localparam int SCAN_DIV = 8;
    localparam int GUARD    = 2;
    localparam int FRAME    = NDIG * SCAN_DIV;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    seg7_scan_drv_if #(.NDIG(NDIG)) bus ();

    seg7_scan_drv #(
        .NDIG     (NDIG),
        .SCAN_DIV (SCAN_DIV),
        .GUARD    (GUARD)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checkCnt = 0;
    int passCnt  = 0;

    // Reference model state
    int          n;
    logic [15:0] mDig;
    logic [3:0]  mDp;
    logic [3:0]  expAn;
    logic [6:0]  expSeg;
    logic        expDp;
    logic        expFt;

    function automatic logic [6:0] refSeg(input logic [3:0] v);
        case (v)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return 7'h3F;
        endcase
    endfunction

    // Called right after each rising edge, before the bench touches inputs.
    // Outputs after edge n describe the scan position n-1 edges after reset.
    task automatic modelTick();
        int   pc;
        int   pi;
        bit   allZero;
        n++;
        pc    = (n - 1) % SCAN_DIV;
        pi    = ((n - 1) / SCAN_DIV) % NDIG;
        expFt = ((n % FRAME) == 0);
        if (pc < GUARD) begin
            expAn  = 4'hF;
            expSeg = 7'h7F;
            expDp  = 1'b1;
        end else begin
            expAn     = 4'hF;
            expAn[pi] = 1'b0;
            allZero   = 1'b1;
            for (int j = pi; j < NDIG; j++) begin
                if (mDig[4*j +: 4] != 4'd0) allZero = 1'b0;
            end
            expSeg = (bus.blank_lz && pi > 0 && allZero) ? 7'h7F : refSeg(mDig[4*pi +: 4]);
            expDp  = ~mDp[pi];
        end
        if (expFt) begin
            mDig = bus.digits;
            mDp  = bus.dp_in;
        end
    endtask

    task automatic modelReset();
        n    = 0;
        mDig = '0;
        mDp  = '0;
    endtask

    task automatic applyStimulus(input logic [15:0] d, input logic [3:0] p, input logic b);
        bus.digits   = d;
        bus.dp_in    = p;
        bus.blank_lz = b;
    endtask

    function automatic logic [15:0] randDigits();
        logic [15:0] v;
        for (int k = 0; k < NDIG; k++) begin
            v[4*k +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
        end
        return v;
    endfunction

    task automatic test_reset();
        applyStimulus(16'h9876, 4'hF, 1'b0);
        rst_n = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checkCnt++;
        if (bus.an !== 4'hF) $display("[TB] FAIL reset_an got=%h want=%h", bus.an, 4'hF);
        else passCnt++;
        checkCnt++;
        if (bus.seg !== 7'h7F) $display("[TB] FAIL reset_seg got=%h want=%h", bus.seg, 7'h7F);
        else passCnt++;
        checkCnt++;
        if (bus.dp !== 1'b1) $display("[TB] FAIL reset_dp got=%b want=1", bus.dp);
        else passCnt++;
        checkCnt++;
        if (bus.frame_tick !== 1'b0) $display("[TB] FAIL reset_ft got=%b want=0", bus.frame_tick);
        else passCnt++;
        @(negedge clk);
        rst_n = 1'b1;
        modelReset();
    endtask

    task automatic test_first_frame();
        for (int c = 0; c < FRAME; c++) begin
            @(posedge clk);
            modelTick();
            #1;
            checkCnt++;
            if ({bus.an, bus.seg, bus.dp, bus.frame_tick} !== {expAn, expSeg, expDp, expFt})
                $display("[TB] FAIL first_frame n=%0d an=%b/%b seg=%h/%h dp=%b/%b ft=%b/%b",
                         n, bus.an, expAn, bus.seg, expSeg, bus.dp, expDp, bus.frame_tick, expFt);
            else passCnt++;
            applyStimulus(randDigits(), 4'($urandom_range(0, 15)), 1'b0);
        end
    endtask

    task automatic test_scan_decode();
        int ftSeen = 0;
        applyStimulus(16'h1234, 4'b0100, 1'b0);
        for (int c = 0; c < 3 * FRAME; c++) begin
            @(posedge clk);
            modelTick();
            #1;
            ftSeen += int'(bus.frame_tick);
            checkCnt++;
            if ({bus.an, bus.seg, bus.dp, bus.frame_tick} !== {expAn, expSeg, expDp, expFt})
                $display("[TB] FAIL scan_decode n=%0d an=%b/%b seg=%h/%h dp=%b/%b ft=%b/%b",
                         n, bus.an, expAn, bus.seg, expSeg, bus.dp, expDp, bus.frame_tick, expFt);
            else passCnt++;
        end
        checkCnt++;
        if (ftSeen != 3) $display("[TB] FAIL frame_tick_rate got=%0d want=3", ftSeen);
        else passCnt++;
    endtask

    task automatic test_blanking();
        logic [15:0] pats [3] = '{16'h0050, 16'h0000, 16'h00A0};
        for (int p = 0; p < 3; p++) begin
            applyStimulus(pats[p], 4'b0000, 1'b1);
            for (int c = 0; c < 2 * FRAME; c++) begin
                @(posedge clk);
                modelTick();
                #1;
                checkCnt++;
                if ({bus.an, bus.seg, bus.dp, bus.frame_tick} !== {expAn, expSeg, expDp, expFt})
                    $display("[TB] FAIL blanking pat=%h n=%0d an=%b/%b seg=%h/%h dp=%b/%b ft=%b/%b",
                             pats[p], n, bus.an, expAn, bus.seg, expSeg, bus.dp, expDp,
                             bus.frame_tick, expFt);
                else passCnt++;
            end
        end
    endtask

    task automatic test_tearing();
        applyStimulus(16'h5678, 4'b0001, 1'b0);
        for (int c = 0; c < 3 * FRAME; c++) begin
            @(posedge clk);
            modelTick();
            #1;
            checkCnt++;
            if ({bus.an, bus.seg, bus.dp, bus.frame_tick} !== {expAn, expSeg, expDp, expFt})
                $display("[TB] FAIL tearing n=%0d an=%b/%b seg=%h/%h dp=%b/%b ft=%b/%b",
                         n, bus.an, expAn, bus.seg, expSeg, bus.dp, expDp, bus.frame_tick, expFt);
            else passCnt++;
            if ((n % FRAME) == FRAME / 2) applyStimulus(16'h9012, 4'b1000, 1'b0);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 8 * FRAME; c++) begin
            @(posedge clk);
            modelTick();
            #1;
            checkCnt++;
            if ({bus.an, bus.seg, bus.dp, bus.frame_tick} !== {expAn, expSeg, expDp, expFt})
                $display("[TB] FAIL random n=%0d an=%b/%b seg=%h/%h dp=%b/%b ft=%b/%b",
                         n, bus.an, expAn, bus.seg, expSeg, bus.dp, expDp, bus.frame_tick, expFt);
            else passCnt++;
            if ($urandom_range(0, 3) == 0)
                applyStimulus(randDigits(), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_async_reset();
        bit found = 1'b0;
        applyStimulus(16'h4321, 4'b0100, 1'b0);
        for (int c = 0; c < 2 * FRAME && !found; c++) begin
            @(posedge clk);
            modelTick();
            #1;
            if (((n / SCAN_DIV) % NDIG) == 2 && (n % SCAN_DIV) == 4) found = 1'b1;
        end
        checkCnt++;
        if (!found) $display("[TB] FAIL async_reset_reach got=not_found want=idx2");
        else passCnt++;
        checkCnt++;
        if (bus.an !== 4'b1011) $display("[TB] FAIL async_pre_an got=%b want=%b", bus.an, 4'b1011);
        else passCnt++;
        #2;
        rst_n = 1'b0;
        #1;
        checkCnt++;
        if ({bus.an, bus.seg, bus.dp, bus.frame_tick} !== {4'hF, 7'h7F, 1'b1, 1'b0})
            $display("[TB] FAIL async_reset an=%b/1111 seg=%h/7f dp=%b/1 ft=%b/0",
                     bus.an, bus.seg, bus.dp, bus.frame_tick);
        else passCnt++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        modelReset();
        for (int c = 0; c < 2 * FRAME; c++) begin
            @(posedge clk);
            modelTick();
            #1;
            checkCnt++;
            if ({bus.an, bus.seg, bus.dp, bus.frame_tick} !== {expAn, expSeg, expDp, expFt})
                $display("[TB] FAIL after_reset n=%0d an=%b/%b seg=%h/%h dp=%b/%b ft=%b/%b",
                         n, bus.an, expAn, bus.seg, expSeg, bus.dp, expDp, bus.frame_tick, expFt);
            else passCnt++;
        end
    endtask

    initial begin
        modelReset();
        test_reset();
        test_first_frame();
        test_scan_decode();
        test_blanking();
        test_tearing();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule

// File: doc/seg7_scan_drv.md
Name: seg7_scan_drv

Overview:
Time-multiplexed 7-segment display driver. It sits directly downstream of the cascaded BCD counter digits and consumes their packed 4-bit values. It scans NDIG digits onto a shared common-anode segment bus, with one anode enabled at a time. It snapshots the digit bus once per frame to prevent tearing, and supports leading-zero blanking, decimal points and an anti-ghosting guard interval.

Parameters:
NDIG, 4, number of digits scanned; legal range 1..8.
SCAN_DIV, 50000, clk cycles per digit slot; must be > GUARD.
GUARD, 16, cycles at the start of each slot with all anodes off; 0 disables the guard.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-low
digits  in  4*NDIG  packed BCD digits; digits[3:0] is digit 0 (least significant, rightmost)
dp_in  in  NDIG  decimal point request per digit, 1 = lit
blank_lz  in  1  1 = blank leading zeros
seg  out  7  {g,f,e,d,c,b,a}, active-low
dp  out  1  decimal point segment, active-low
an  out  NDIG  anode enables, active-low, one-hot-low or all-high
frame_tick  out  1  one-cycle pulse when the snapshot reloads

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-low.
- Reset state: cnt=0, idx=0, snap_dig=0, snap_dp=0. Outputs: an=all 1, seg=7'h7F, dp=1, frame_tick=0.
- Reset asserted mid-scan forces the reset state immediately, with no wait for a clock edge.
- Slot counter cnt runs 0..SCAN_DIV-1:
  - At cnt==SCAN_DIV-1: cnt<=0 and idx<=idx+1.
  - idx wraps from NDIG-1 to 0.
- Snapshot:
  - On the terminal count with idx==NDIG-1, snap_dig<=digits and snap_dp<=dp_in.
  - frame_tick is asserted in the same cycle that the snapshot registers load.
  - The first frame after reset displays the zero snapshot.
- Input changes between snapshots are never visible on the outputs.
- Outputs are registered, one-cycle latency from (idx, cnt, snap_dig, snap_dp).
- When cnt<GUARD: an=all 1, seg=7'h7F, dp=1.
- Otherwise: an[idx]=0 and all other an bits=1. seg is the decode of snap_dig digit idx; dp=~snap_dp[idx].
- Decode, active-low:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10.
  - Invalid 10..15 = 3F (dash, segment g only).
- Leading-zero blanking, when blank_lz=1:
  - Digit i>0 is blanked (seg=7F) if digit i and all higher snapshot digits equal 0.
  - Digit 0 is never blanked.
  - An invalid code counts as non-zero.
  - dp is unaffected by blanking.
  - The anode is still enabled for a blanked digit.
- blank_lz is sampled live, not snapshotted.
- NDIG=1: idx is constant 0, and the snapshot reloads every slot.

Decomposition:
- Package seg7_pkg holds:
  - the segment code constants: SEG_0..SEG_9, SEG_DASH=7'h3F, SEG_OFF=7'h7F;
  - the localparam width function for cnt, $clog2(SCAN_DIV), and for idx.
- One combinational sub-module, seg7_dec: 4-bit BCD in, 7-bit active-low segment out, dash for invalid codes.
- The top level holds the prescaler, index, snapshot and blanking logic, plus the output registers.

Test Plan:
All scenarios use NDIG=4, SCAN_DIV=8, GUARD=2.
- Reset:
  - Hold rst=0 for 5 cycles -> an=4'hF, seg=7F, dp=1, frame_tick=0.
  - Release rst -> the first frame shows digit 0 as 40 and digits 1..3 as 40 (blank_lz=0).
- Scan and decode with digits=16'h1234, dp_in=4'b0100, blank_lz=0:
  - Frame_tick pulses once per 32 cycles.
  - In the next frame, with a 1-cycle lag: slot 0 gives an=1110 seg=19; slot 1 gives an=1101 seg=30; slot 2 gives an=1011 seg=24 dp=0; slot 3 gives an=0111 seg=79.
  - Cycles 0..1 of each slot show an=F.
- Leading-zero blanking, digits=16'h0050, blank_lz=1:
  - Digits 3 and 2 show 7F.
  - Digit 1 shows 12.
  - Digit 0 shows 40, not blanked.
  - digits=0 -> only digit 0 shows 40.
- Invalid code, digits=16'h00A0, blank_lz=1:
  - Digit 1 shows 3F.
  - Digits 3 and 2 are blanked.
- Tearing: change digits mid-frame -> the outputs keep the old values until the next frame_tick, then switch on the following frame.
- Asynchronous reset mid-slot: assert rst between clock edges at idx=2 -> the outputs go to the reset values immediately, and the scan restarts at idx=0 with cnt=0.
